// File: rtl/rom_arbiter_if.sv
// Request/response channels for the IFU and LSU plus the shared ROM read port.
// The slave modport is the arbiter's view; the master modport is the requester/ROM side.
interface rom_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  ifu_req_i;
  logic [ADDR_WIDTH-1:0] ifu_addr_i;
  logic                  ifu_gnt_o;
  logic                  ifu_rvalid_o;
  logic [DATA_WIDTH-1:0] ifu_rdata_o;
  logic                  ifu_err_o;
  logic                  ifu_rready_i;

  logic                  lsu_req_i;
  logic [ADDR_WIDTH-1:0] lsu_addr_i;
  logic                  lsu_gnt_o;
  logic                  lsu_rvalid_o;
  logic [DATA_WIDTH-1:0] lsu_rdata_o;
  logic                  lsu_err_o;
  logic                  lsu_rready_i;

  logic                  rom_rena_o;
  logic [ADDR_WIDTH-1:0] rom_raddr_o;
  logic [DATA_WIDTH-1:0] rom_rdata_i;

  modport slave (
    input  ifu_req_i, ifu_addr_i, ifu_rready_i,
    input  lsu_req_i, lsu_addr_i, lsu_rready_i,
    input  rom_rdata_i,
    output ifu_gnt_o, ifu_rvalid_o, ifu_rdata_o, ifu_err_o,
    output lsu_gnt_o, lsu_rvalid_o, lsu_rdata_o, lsu_err_o,
    output rom_rena_o, rom_raddr_o
  );

  modport master (
    output ifu_req_i, ifu_addr_i, ifu_rready_i,
    output lsu_req_i, lsu_addr_i, lsu_rready_i,
    output rom_rdata_i,
    input  ifu_gnt_o, ifu_rvalid_o, ifu_rdata_o, ifu_err_o,
    input  lsu_gnt_o, lsu_rvalid_o, lsu_rdata_o, lsu_err_o,
    input  rom_rena_o, rom_raddr_o
  );
endinterface

// File: rtl/rom_arbiter.sv
// Shares the single-ported instruction ROM between IFU and LSU: fixed LSU priority with an
// IFU starvation guard, or alternating winner on conflict when ROM_ARB_RR_EN is defined.
module rom_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int ROM_DEPTH    = 4096,
  parameter int STARVE_LIMIT = 4
) (
  input logic          clk,
  input logic          arst_n,
  rom_arbiter_if.slave bus
);

  function automatic logic addr_err(input logic [ADDR_WIDTH-1:0] addr);
    logic [ADDR_WIDTH-1:0] word_idx;
    word_idx = {2'b00, addr[ADDR_WIDTH-1:2]};
    addr_err = (addr[1:0] != 2'b00) || (word_idx >= ADDR_WIDTH'(ROM_DEPTH));
  endfunction

  logic                  ifu_elig_s, lsu_elig_s;
  logic                  ifu_win_s, lsu_win_s;
  logic                  ifu_prio_s;
  logic                  gnt_err_s;
  logic [ADDR_WIDTH-1:0] gnt_addr_s;
  logic [DATA_WIDTH-1:0] load_data_s;

  logic                  ifu_rvalid_q, ifu_rvalid_d, ifu_err_q, ifu_err_d;
  logic                  lsu_rvalid_q, lsu_rvalid_d, lsu_err_q, lsu_err_d;
  logic [DATA_WIDTH-1:0] ifu_rdata_q, ifu_rdata_d, lsu_rdata_q, lsu_rdata_d;

`ifdef ROM_ARB_RR_EN
  logic last_lsu_q, last_lsu_d;

  // On conflict the IFU wins whenever the LSU won last
  always_comb begin
    ifu_prio_s = last_lsu_q;
  end
`else
  localparam int                CNT_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(STARVE_LIMIT);
  logic [CNT_W-1:0] starve_q, starve_d;

  // IFU is forced to win once it has lost STARVE_LIMIT times in a row
  always_comb begin
    ifu_prio_s = (starve_q == CNT_MAX);
  end
`endif

  // Eligibility, winner selection and ROM port; nothing is granted while in reset
  always_comb begin
    ifu_elig_s = arst_n && bus.ifu_req_i && (!ifu_rvalid_q || bus.ifu_rready_i);
    lsu_elig_s = arst_n && bus.lsu_req_i && (!lsu_rvalid_q || bus.lsu_rready_i);
    ifu_win_s  = 1'b0;
    lsu_win_s  = 1'b0;
    case ({ifu_elig_s, lsu_elig_s})
      2'b11: begin
        ifu_win_s = ifu_prio_s;
        lsu_win_s = !ifu_prio_s;
      end
      2'b10:   ifu_win_s = 1'b1;
      2'b01:   lsu_win_s = 1'b1;
      default: begin
        ifu_win_s = 1'b0;
        lsu_win_s = 1'b0;
      end
    endcase
    gnt_addr_s      = ifu_win_s ? bus.ifu_addr_i : bus.lsu_addr_i;
    gnt_err_s       = addr_err(gnt_addr_s);
    load_data_s     = gnt_err_s ? {DATA_WIDTH{1'b0}} : bus.rom_rdata_i;
    bus.ifu_gnt_o   = ifu_win_s;
    bus.lsu_gnt_o   = lsu_win_s;
    bus.rom_rena_o  = (ifu_win_s || lsu_win_s) && !gnt_err_s;
    bus.rom_raddr_o = bus.rom_rena_o ? gnt_addr_s : {ADDR_WIDTH{1'b0}};
  end

  // Response buffers: a grant loads, a completed handshake without reload clears
  always_comb begin
    ifu_rvalid_d = ifu_rvalid_q;
    ifu_rdata_d  = ifu_rdata_q;
    ifu_err_d    = ifu_err_q;
    lsu_rvalid_d = lsu_rvalid_q;
    lsu_rdata_d  = lsu_rdata_q;
    lsu_err_d    = lsu_err_q;
    if (ifu_win_s) begin
      ifu_rvalid_d = 1'b1;
      ifu_rdata_d  = load_data_s;
      ifu_err_d    = gnt_err_s;
    end else if (ifu_rvalid_q && bus.ifu_rready_i) begin
      ifu_rvalid_d = 1'b0;
      ifu_rdata_d  = {DATA_WIDTH{1'b0}};
      ifu_err_d    = 1'b0;
    end else begin
      ifu_rvalid_d = ifu_rvalid_q;
    end
    if (lsu_win_s) begin
      lsu_rvalid_d = 1'b1;
      lsu_rdata_d  = load_data_s;
      lsu_err_d    = gnt_err_s;
    end else if (lsu_rvalid_q && bus.lsu_rready_i) begin
      lsu_rvalid_d = 1'b0;
      lsu_rdata_d  = {DATA_WIDTH{1'b0}};
      lsu_err_d    = 1'b0;
    end else begin
      lsu_rvalid_d = lsu_rvalid_q;
    end
  end

`ifdef ROM_ARB_RR_EN
  // Remember who was granted most recently
  always_comb begin
    if (lsu_win_s) begin
      last_lsu_d = 1'b1;
    end else if (ifu_win_s) begin
      last_lsu_d = 1'b0;
    end else begin
      last_lsu_d = last_lsu_q;
    end
  end
`else
  // Count consecutive IFU losses, saturating at the limit
  always_comb begin
    starve_d = starve_q;
    if (!bus.ifu_req_i || ifu_win_s) begin
      starve_d = {CNT_W{1'b0}};
    end else if (ifu_elig_s && (starve_q != CNT_MAX)) begin
      starve_d = starve_q + CNT_W'(1);
    end else begin
      starve_d = starve_q;
    end
  end
`endif

  // State registers; reset discards any in-flight response
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      ifu_rvalid_q <= 1'b0;
      ifu_rdata_q  <= {DATA_WIDTH{1'b0}};
      ifu_err_q    <= 1'b0;
      lsu_rvalid_q <= 1'b0;
      lsu_rdata_q  <= {DATA_WIDTH{1'b0}};
      lsu_err_q    <= 1'b0;
`ifdef ROM_ARB_RR_EN
      last_lsu_q   <= 1'b1;
`else
      starve_q     <= {CNT_W{1'b0}};
`endif
    end else begin
      ifu_rvalid_q <= ifu_rvalid_d;
      ifu_rdata_q  <= ifu_rdata_d;
      ifu_err_q    <= ifu_err_d;
      lsu_rvalid_q <= lsu_rvalid_d;
      lsu_rdata_q  <= lsu_rdata_d;
      lsu_err_q    <= lsu_err_d;
`ifdef ROM_ARB_RR_EN
      last_lsu_q   <= last_lsu_d;
`else
      starve_q     <= starve_d;
`endif
    end
  end

  assign bus.ifu_rvalid_o = ifu_rvalid_q;
  assign bus.ifu_rdata_o  = ifu_rdata_q;
  assign bus.ifu_err_o    = ifu_err_q;
  assign bus.lsu_rvalid_o = lsu_rvalid_q;
  assign bus.lsu_rdata_o  = lsu_rdata_q;
  assign bus.lsu_err_o    = lsu_err_q;

endmodule

// File: doc/rom_arbiter.md
# rom_arbiter

Two-port arbiter that shares the single-ported instruction ROM between the instruction-fetch unit (IFU) and the load/store unit (LSU) for constant-data reads. It sits between both requesters and the ROM read port:
- grants at most one access per cycle;
- drives the ROM read enable and address;
- registers the combinational ROM data into a per-requester response buffer with a valid/ready handshake.

Fixed LSU priority is used, with a starvation guard for the IFU. Misaligned and out-of-range accesses are flagged as errors.

## Interface
Parameters:
- ADDR_WIDTH, 32, byte-address width
- DATA_WIDTH, 32, ROM word width
- ROM_DEPTH, 4096, ROM words; word index is addr[31:2]
- STARVE_LIMIT, 4, consecutive IFU losses before the IFU is forced to win (≥1)

Ports:
- clk  in  1  single clock, rising edge
- arst_n  in  1  asynchronous active-low reset
- ifu_req_i  in  1  IFU read request
- ifu_addr_i  in  ADDR_WIDTH  IFU byte address
- ifu_gnt_o  out  1  IFU request accepted this cycle
- ifu_rvalid_o  out  1  IFU response valid
- ifu_rdata_o  out  DATA_WIDTH  IFU response data
- ifu_err_o  out  1  IFU response is an error
- ifu_rready_i  in  1  IFU accepts response
- lsu_req_i, lsu_addr_i, lsu_gnt_o, lsu_rvalid_o, lsu_rdata_o, lsu_err_o, lsu_rready_i: same as the IFU ports, for the LSU
- rom_rena_o  out  1  ROM read enable
- rom_raddr_o  out  ADDR_WIDTH  ROM byte address
- rom_rdata_i  in  DATA_WIDTH  ROM combinational read data

## Operation
**Eligibility**
- A requester is eligible when req_i=1 and its response buffer is empty, or is being drained this cycle (rvalid_o && rready_i).

**Arbitration** (combinational, same cycle)
- Only LSU eligible → LSU granted.
- Only IFU eligible → IFU granted.
- Both eligible → LSU granted, unless starve_cnt == STARVE_LIMIT; then IFU is granted.
- gnt_o is asserted only to the winner.

**ROM port**
- rom_rena_o = 1 iff a grant is issued and the granted address is aligned and in range.
- rom_raddr_o = granted address; 0 when rom_rena_o = 0.

**Error check**
- Error when addr[1:0] != 0, or addr[31:2] >= ROM_DEPTH.
- An erroring request is still granted and consumes the slot.
- Its response has err_o=1 and rdata_o=0.

**Response buffer** (one per requester)
- On grant, at the next clock edge: rvalid←1, rdata←rom_rdata_i (or 0 on error), err←error flag.
- The buffer holds until rvalid && rready; it clears at that edge unless a new grant reloads it in the same cycle.

**Starvation counter**
- Width clog2(STARVE_LIMIT+1).
- Increments (saturating) on cycles where the IFU is eligible but not granted.
- Clears when the IFU is granted or ifu_req_i = 0.

**Reset**
- All rvalid/err/rdata outputs are 0 and starve_cnt = 0.
- gnt and rom_rena_o are forced to 0 while arst_n = 0.
- An in-flight response is discarded; requesters must re-issue after reset.

## Timing
- Grant in the request cycle N; response visible in cycle N+1 (latency 1). Throughput is one grant per cycle in total.
- Back-to-back grants to the same requester are allowed when its response is consumed in the same cycle (rready = 1 in every cycle gives 1 word/cycle).
- A stalled response (rready = 0) blocks only that requester; the other requester proceeds.
- Requests are not registered. The requester must hold req/addr until gnt_o is seen; addr may change only after the grant.
- Reset deassertion: the first grant can occur in the first cycle with arst_n = 1.

## Configuration
- ROM_ARB_RR_EN defined:
  - On conflict, the winner alternates, using a 1-bit last-winner register that resets to LSU (so the first conflict goes to the IFU).
  - starve_cnt is not implemented.
- Not defined: fixed LSU priority with the STARVE_LIMIT guard, as described above.

## Test plan
- **Reset values:** reset asserted mid-response with ifu_rvalid_o=1 → all rvalid/err/rdata outputs 0 immediately, no grant while arst_n=0.
- **Single read:** IFU reads 0x0000_0010 with ROM word 4 = 0xDEAD_BEEF → gnt in cycle N; rvalid=1, rdata=0xDEAD_BEEF, err=0 in N+1.
- **Starvation guard:** both requesters request every cycle, both rready=1, STARVE_LIMIT=4 → LSU wins 4 cycles, IFU wins the 5th, pattern repeats. With ROM_ARB_RR_EN → strict alternation starting with the IFU.
- **Errors:** LSU reads 0x0000_0006 → granted, rom_rena_o=0, next-cycle err=1, rdata=0. IFU reads 0x0000_4000 (word 4096) → err=1.
- **Backpressure:** LSU rready=0 for 3 cycles with lsu_req_i held → no further LSU grant, rvalid/rdata stable; IFU granted meanwhile. Releasing rready → the same-cycle LSU grant reloads the buffer.
